axi4_burst_mem_slave: RTL and testbench

- Parametrised AXI4 memory-mapped slave; successor to the fixed-width INCR-only slave.
- Adds FIXED/INCR/WRAP bursts, WSTRB byte strobes and SLVERR error responses.
- Independent read and write FSMs share one single-port memory through a round-robin arbiter.
- Sits between the bench/master interface and the external word-addressed memory model; memory read latency is 1 cycle.

---
 rtl/axi4_burst_mem_slave_pkg.sv | 30 +++
 rtl/axi4_addr_gen.sv | 32 +++
 rtl/axi4_burst_mem_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_burst_mem_slave_pkg.sv
// Shared types for the AXI4 burst memory slave: burst encodings, response codes
// and the FSM state sets used by the top and the address generator.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rstate_e;

  function automatic logic is_valid_wrap_len(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; one instance
// per channel, fed from the latched burst descriptor.
module axi4_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0] sum;

  always_comb begin
    incr  = ADDR_WIDTH'(1) << size;
    // Wrap window is (len+1) beats wide and naturally aligned to its own size.
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    sum   = addr + incr;
    case (burst_e'(burst))
      FIXED:   next_addr = addr;
      INCR:    next_addr = sum;
      WRAP:    next_addr = (addr & ~wmask) | (sum & wmask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory-mapped slave with FIXED/INCR/WRAP bursts, byte strobes and SLVERR.
// Read and write FSMs share one single-port memory via a round-robin arbiter.
module axi4_burst_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  output logic [$clog2(DEPTH)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int LSB = $clog2(DATA_WIDTH/8);
  localparam int IW  = $clog2(DEPTH);

  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] start_w, last_w;
    logic [12:0] end_b;
    logic        e;
    start_w = 32'(a) >> LSB;
    last_w  = start_w + 32'(len);
    end_b   = 13'(a[11:0]) + ((13'(len) + 13'd1) << LSB);
    e = (size != 3'(LSB)) || (burst == 2'b11) || (a[LSB-1:0] != '0) ||
        (burst_e'(burst) == WRAP && !is_valid_wrap_len(len));
    if (burst_e'(burst) == INCR)
      e = e || (start_w >= 32'(DEPTH)) || (last_w >= 32'(DEPTH)) || (end_b > 13'h1000);
    return e;
  endfunction

  wstate_e               wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_nxt;
  logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d, wlerr_q, wlerr_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, awready_d;

  rstate_e               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rerr_q, rerr_d, rfirst_q, rfirst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  arready_q, arready_d;

  logic prio_w_q, prio_w_d;
  logic w_req, r_req, grant_w, grant_r;

  axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
    .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q), .next_addr(waddr_nxt)
  );
  axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
    .addr(raddr_q), .len(rlen_q), .size(rsize_q), .burst(rburst_q), .next_addr(raddr_nxt)
  );

  // Erroneous bursts never request the memory; a tie goes to the side not granted last.
  assign w_req   = (wstate_q == W_DATA) && WVALID && !werr_q;
  assign r_req   = (rstate_q == R_ADDR) && !rerr_q;
  assign grant_w = w_req && (!r_req || prio_w_q);
  assign grant_r = r_req && (!w_req || !prio_w_q);

  assign AWREADY = awready_q;
  assign ARREADY = arready_q;
  assign WREADY  = (wstate_q == W_DATA) && (werr_q || grant_w);
  assign BVALID  = (wstate_q == W_RESP);
  assign BRESP   = bresp_q;
  assign RVALID  = (rstate_q == R_DATA);
  assign RRESP   = (RVALID && rerr_q) ? SLVERR : OKAY;
  assign RLAST   = RVALID && (rbeat_q == rlen_q);
  // Memory data is live only in the R_DATA entry cycle; the register holds it afterwards.
  assign RDATA   = rfirst_q ? (rerr_q ? '0 : mem_rdata) : rdata_q;

  always_comb begin
    mem_en    = grant_w || grant_r;
    mem_we    = grant_w;
    mem_wstrb = grant_w ? WSTRB : '0;
    mem_wdata = grant_w ? WDATA : '0;
    mem_addr  = grant_w ? waddr_q[LSB +: IW] : (grant_r ? raddr_q[LSB +: IW] : '0);
  end

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wbeat_d  = wbeat_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    werr_d   = werr_q;
    wlerr_d  = wlerr_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_IDLE: if (AWVALID && awready_q) begin
        waddr_d  = AWADDR;
        wlen_d   = AWLEN;
        wsize_d  = AWSIZE;
        wburst_d = AWBURST;
        werr_d   = burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
        wlerr_d  = 1'b0;
        wbeat_d  = '0;
        wstate_d = W_DATA;
      end
      W_DATA: if (WVALID && WREADY) begin
        wbeat_d = 8'(wbeat_q + 8'd1);
        waddr_d = waddr_nxt;
        if (wbeat_q == wlen_q) begin
          wstate_d = W_RESP;
          bresp_d  = (werr_q || wlerr_q || !WLAST) ? SLVERR : OKAY;
        end else if (WLAST) begin
          wlerr_d = 1'b1;
        end
      end
      W_RESP: if (BREADY) begin
        wstate_d = W_IDLE;
        bresp_d  = OKAY;
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
  end

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rbeat_d  = rbeat_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rerr_d   = rerr_q;
    rfirst_d = rfirst_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (ARVALID && arready_q) begin
        raddr_d  = ARADDR;
        rlen_d   = ARLEN;
        rsize_d  = ARSIZE;
        rburst_d = ARBURST;
        rerr_d   = burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
        rbeat_d  = '0;
        rstate_d = R_ADDR;
      end
      R_ADDR: if (rerr_q || grant_r) begin
        rstate_d = R_DATA;
        rfirst_d = 1'b1;
      end
      R_DATA: begin
        if (rfirst_q) begin
          rdata_d  = RDATA;
          rfirst_d = 1'b0;
        end
        if (RREADY) begin
          if (rbeat_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            rbeat_d  = 8'(rbeat_q + 8'd1);
            raddr_d  = raddr_nxt;
            rstate_d = R_ADDR;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  always_comb begin
    prio_w_d = prio_w_q;
    if (grant_w)      prio_w_d = 1'b0;
    else if (grant_r) prio_w_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      wlerr_q   <= 1'b0;
      bresp_q   <= OKAY;
      awready_q <= 1'b0;
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rerr_q    <= 1'b0;
      rfirst_q  <= 1'b0;
      rdata_q   <= '0;
      arready_q <= 1'b0;
      prio_w_q  <= 1'b1;
    end else begin
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      wlerr_q   <= wlerr_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      rstate_q  <= rstate_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rerr_q    <= rerr_d;
      rfirst_q  <= rfirst_d;
      rdata_q   <= rdata_d;
      arready_q <= arready_d;
      prio_w_q  <= prio_w_d;
    end
  end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: bursts, strobes, error responses,
// arbitration between concurrent bursts and reset mid-burst.
module tb_axi4_burst_mem_slave;
  import axi4_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [15:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 ACLK = ~ACLK;

  axi4_burst_mem_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word-addressed memory, one-cycle read latency, byte strobes on write.
  logic [31:0] mem [1024] = '{default: '0};
  int          memops = 0;
  bit          log_on = 1'b0;
  bit          glog[$];

  always @(posedge ACLK) begin
    if (mem_en) begin
      memops <= memops + 1;
      if (log_on) glog.push_back(mem_we);
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  logic [1:0]  resp;
  int          ops0;
  logic [15:0] gpack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [15:0] a, input logic [7:0] len, input logic [1:0] bu,
                         input logic [2:0] sz);
    int t;
    t = 0;
    @(negedge ACLK);
    AWADDR = a; AWLEN = len; AWBURST = bu; AWSIZE = sz; AWVALID = 1'b1;
    #1;
    while (!AWREADY && t < 50) begin @(negedge ACLK); #1; t++; end
    chk("aw_timeout", 32'(t >= 50), 32'd0);
    @(posedge ACLK); #1 AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [15:0] a, input logic [7:0] len, input logic [1:0] bu,
                         input logic [2:0] sz);
    int t;
    t = 0;
    @(negedge ACLK);
    ARADDR = a; ARLEN = len; ARBURST = bu; ARSIZE = sz; ARVALID = 1'b1;
    #1;
    while (!ARREADY && t < 50) begin @(negedge ACLK); #1; t++; end
    chk("ar_timeout", 32'(t >= 50), 32'd0);
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t;
    t = 0;
    @(negedge ACLK);
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
    #1;
    while (!WREADY && t < 50) begin @(negedge ACLK); #1; t++; end
    chk("w_timeout", 32'(t >= 50), 32'd0);
    @(posedge ACLK);
  endtask

  task automatic b_recv(output logic [1:0] r);
    int t;
    t = 0;
    @(negedge ACLK);
    BREADY = 1'b1;
    #1;
    while (!BVALID && t < 50) begin @(negedge ACLK); #1; t++; end
    chk("b_timeout", 32'(t >= 50), 32'd0);
    r = BRESP;
    @(posedge ACLK); #1 BREADY = 1'b0;
  endtask

  // lmode 0: WLAST on final beat only; 1: WLAST never; 2: WLAST on every beat.
  task automatic wr_burst(input logic [15:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [2:0] sz, input logic [31:0] d0, input logic [3:0] s,
                          input int lmode, output logic [1:0] r);
    logic l;
    aw_send(a, len, bu, sz);
    for (int i = 0; i <= int'(len); i++) begin
      l = (lmode == 0) ? (i == int'(len)) : (lmode == 2);
      w_beat(d0 + 32'(i), s, l);
    end
    #1 WVALID = 1'b0; WLAST = 1'b0;
    b_recv(r);
  endtask

  task automatic r_recv(input int nb, input bit stall);
    int t;
    RREADY = !stall;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      @(negedge ACLK); #1;
      while (!RVALID && t < 50) begin @(negedge ACLK); #1; t++; end
      chk("r_timeout", 32'(t >= 50), 32'd0);
      if (stall && b == 0) begin
        repeat (2) @(negedge ACLK);
        #1 RREADY = 1'b1;
      end
      rd_d[b] = RDATA; rd_r[b] = RRESP; rd_l[b] = RLAST;
      @(posedge ACLK);
    end
    #1 RREADY = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge ACLK); @(negedge ACLK); #1;
    chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0);
    chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", RDATA, 0);     chk("rst_rlast", RLAST, 0);
    @(negedge ACLK); ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    chk("post_rst_awready", AWREADY, 1); chk("post_rst_arready", ARREADY, 1);

    // INCR write then matching read
    wr_burst(16'h0010, 8'd3, 2'b01, 3'd2, 32'hA0, 4'hF, 0, resp);
    chk("incr_bresp", resp, OKAY);
    for (int i = 0; i < 4; i++) chk("incr_mem", mem[4+i], 32'hA0 + 32'(i));
    ar_send(16'h0010, 8'd3, 2'b01, 3'd2);
    r_recv(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rd_d[i], 32'hA0 + 32'(i));
      chk("incr_rresp", rd_r[i], OKAY);
      chk("incr_rlast", rd_l[i], (i == 3) ? 32'd1 : 32'd0);
    end

    // WRAP read 0x38 LEN3: words 14,15,12,13; first beat stalled with RREADY low
    wr_burst(16'h0030, 8'd3, 2'b01, 3'd2, 32'hC0, 4'hF, 0, resp);
    chk("wrap_setup_bresp", resp, OKAY);
    ar_send(16'h0038, 8'd3, 2'b10, 3'd2);
    r_recv(4, 1'b1);
    chk("wrap_rdata0", rd_d[0], 32'hC2); chk("wrap_rdata1", rd_d[1], 32'hC3);
    chk("wrap_rdata2", rd_d[2], 32'hC0); chk("wrap_rdata3", rd_d[3], 32'hC1);
    chk("wrap_rresp", rd_r[3], OKAY);    chk("wrap_rlast", rd_l[3], 1);

    // Acceptance-time errors
    ops0 = memops;
    wr_burst(16'h0FF8, 8'd3, 2'b01, 3'd2, 32'hBAD0, 4'hF, 0, resp);
    chk("err_4kb_bresp", resp, SLVERR);
    chk("err_4kb_memops", 32'(memops - ops0), 0);
    wr_burst(16'h0040, 8'd2, 2'b10, 3'd2, 32'hBAD1, 4'hF, 0, resp);
    chk("err_wraplen_bresp", resp, SLVERR);
    wr_burst(16'h0040, 8'd0, 2'b01, 3'd1, 32'hBAD2, 4'hF, 0, resp);
    chk("err_size_bresp", resp, SLVERR);
    wr_burst(16'h0040, 8'd0, 2'b11, 3'd2, 32'hBAD3, 4'hF, 0, resp);
    chk("err_rsvd_bresp", resp, SLVERR);
    wr_burst(16'h0042, 8'd0, 2'b01, 3'd2, 32'hBAD4, 4'hF, 0, resp);
    chk("err_unalign_bresp", resp, SLVERR);
    chk("err_all_memops", 32'(memops - ops0), 0);
    chk("err_mem_word16", mem[16], 0);
    // WLAST protocol errors
    wr_burst(16'h0140, 8'd1, 2'b01, 3'd2, 32'h50, 4'hF, 1, resp);
    chk("err_nolast_bresp", resp, SLVERR);
    wr_burst(16'h0140, 8'd1, 2'b01, 3'd2, 32'h60, 4'hF, 2, resp);
    chk("err_earlylast_bresp", resp, SLVERR);

    // Byte strobes
    wr_burst(16'h0100, 8'd0, 2'b01, 3'd2, 32'h11223344, 4'hF, 0, resp);
    wr_burst(16'h0100, 8'd0, 2'b00, 3'd2, 32'hFFFFFFFF, 4'b0101, 0, resp);
    chk("strb_bresp", resp, OKAY);
    chk("strb_mem", mem[64], 32'h11FF33FF);
    ar_send(16'h0100, 8'd0, 2'b01, 3'd2);
    r_recv(1, 1'b0);
    chk("strb_rdata", rd_d[0], 32'h11FF33FF);

    // Out-of-range read: one SLVERR beat, no memory access
    ops0 = memops;
    ar_send(16'h1000, 8'd0, 2'b01, 3'd2);
    r_recv(1, 1'b0);
    chk("oor_rresp", rd_r[0], SLVERR); chk("oor_rdata", rd_d[0], 0);
    chk("oor_rlast", rd_l[0], 1);      chk("oor_memops", 32'(memops - ops0), 0);
    @(negedge ACLK); #1;
    chk("oor_rvalid_after", RVALID, 0);

    // Concurrent LEN=7 write and read: grants alternate W,R,...
    log_on = 1'b1;
    fork
      wr_burst(16'h0200, 8'd7, 2'b01, 3'd2, 32'hD0, 4'hF, 0, resp);
      begin
        ar_send(16'h0010, 8'd7, 2'b01, 3'd2);
        r_recv(8, 1'b0);
      end
    join
    log_on = 1'b0;
    chk("conc_bresp", resp, OKAY);
    chk("conc_grants", 32'(glog.size()), 16);
    gpack = '0;
    for (int i = 0; i < 16 && i < glog.size(); i++) gpack[i] = glog[i];
    chk("conc_order", 32'(gpack), 32'h5555);
    for (int i = 0; i < 8; i++) begin
      chk("conc_mem", mem[128+i], 32'hD0 + 32'(i));
      chk("conc_rdata", rd_d[i], (i < 4) ? 32'hA0 + 32'(i) : 32'd0);
    end
    chk("conc_rlast", rd_l[7], 1);

    // Reset during beat 2 of a write burst
    aw_send(16'h0300, 8'd3, 2'b01, 3'd2);
    w_beat(32'hE0, 4'hF, 1'b0);
    w_beat(32'hE1, 4'hF, 1'b0);
    @(negedge ACLK);
    WDATA = 32'hE2; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    #1;
    chk("mid_wready_pre", WREADY, 1);
    ARESETn = 1'b0;
    @(negedge ACLK); #1;
    chk("mid_rst_wready", WREADY, 0);   chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_awready", AWREADY, 0); chk("mid_rst_arready", ARREADY, 0);
    chk("mid_rst_bvalid", BVALID, 0);   chk("mid_rst_rvalid", RVALID, 0);
    WVALID = 1'b0;
    @(negedge ACLK); ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    chk("mid_post_awready", AWREADY, 1); chk("mid_post_arready", ARREADY, 1);
    chk("mid_post_bvalid", BVALID, 0);
    chk("mid_mem_beat0", mem[192], 32'hE0);
    chk("mid_mem_beat2", mem[194], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
